// File: rtl/tlul_pkg.sv
// Shared TL-UL opcode constants, responder FSM states and lane-mask helper.
package tlul_pkg;

    localparam logic [2:0] OP_PUT_FULL       = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL    = 3'd1;
    localparam logic [2:0] OP_GET            = 3'd4;
    localparam logic [2:0] OP_ACCESS_ACK     = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Byte lanes a naturally aligned access of 2^size bytes touches.
    function automatic logic [3:0] lane_mask(input logic [3:0] size, input logic [1:0] addr_lo);
        logic [3:0] m;
        case (size)
            4'd0:    m = 4'b0001 << addr_lo;
            4'd1:    m = 4'b0011 << addr_lo;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tlul_req_check.sv
// Combinational legality check for an incoming TL-UL A-channel request.
module tlul_req_check
    import tlul_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0002_0000,
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic [2:0]       opcode,
    input  logic [3:0]       size,
    input  logic [31:0]      address,
    input  logic [3:0]       mask,
    input  logic             corrupt,
    output logic             legal,
    output logic [IDX_W-1:0] reg_index
);

    // 33-bit window bounds so a window ending at 4 GiB cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = {1'b0, BASE_ADDR} + 33'(NUM_REGS * 4);

    logic op_ok;
    logic size_ok;
    logic aligned;
    logic in_range;
    logic mask_ok;

    always_comb begin
        op_ok    = (opcode == OP_GET) || (opcode == OP_PUT_FULL) || (opcode == OP_PUT_PARTIAL);
        size_ok  = (size <= 4'd2);
        case (size)
            4'd0:    aligned = 1'b1;
            4'd1:    aligned = (address[0] == 1'b0);
            default: aligned = (address[1:0] == 2'b00);
        endcase
        in_range = ({1'b0, address} >= WIN_LO) && ({1'b0, address} < WIN_HI);
        mask_ok  = (opcode != OP_PUT_FULL) || (mask == lane_mask(size, address[1:0]));
        legal    = op_ok && size_ok && aligned && in_range && mask_ok && !corrupt;
    end

    assign reg_index = address[2 +: IDX_W];

endmodule

// File: rtl/tlul_reg_responder.sv
// TL-UL register-window responder with a one-entry response buffer.
module tlul_reg_responder
    import tlul_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0002_0000,
    parameter int unsigned NUM_REGS  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [3:0]  a_size,
    input  logic [1:0]  a_source,
    input  logic [31:0] a_address,
    input  logic [3:0]  a_mask,
    input  logic [31:0] a_data,
    input  logic        a_corrupt,
    output logic        a_ready,
    output logic        d_valid,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [3:0]  d_size,
    output logic [1:0]  d_source,
    output logic        d_denied,
    output logic [31:0] d_data,
    output logic        d_corrupt,
    input  logic        d_ready,
    output logic [7:0]  err_count
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_e            state;
    logic [31:0]       regs [NUM_REGS];
    logic              legal;
    logic [IDX_W-1:0]  reg_index;
    logic              accept;
    logic              is_get;
    logic              unused_param;

    assign unused_param = ^a_param;

    tlul_req_check #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W)
    ) u_check (
        .opcode    (a_opcode),
        .size      (a_size),
        .address   (a_address),
        .mask      (a_mask),
        .corrupt   (a_corrupt),
        .legal     (legal),
        .reg_index (reg_index)
    );

    // Draining and refilling in the same cycle is allowed when d_ready is high.
    assign a_ready = !reset && ((state == EMPTY) || d_ready);
    assign accept  = a_valid && a_ready;
    assign is_get  = (a_opcode == OP_GET);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= EMPTY;
            d_valid   <= 1'b0;
            d_opcode  <= '0;
            d_param   <= '0;
            d_size    <= '0;
            d_source  <= '0;
            d_denied  <= 1'b0;
            d_data    <= '0;
            d_corrupt <= 1'b0;
            err_count <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (accept) begin
            state     <= FULL;
            d_valid   <= 1'b1;
            d_opcode  <= is_get ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;
            d_param   <= '0;
            d_size    <= a_size;
            d_source  <= a_source;
            d_denied  <= !legal;
            d_corrupt <= !legal && is_get;
            d_data    <= (legal && is_get) ? regs[reg_index] : '0;
            if (!legal && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (legal && !is_get) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (a_mask[b]) begin
                        regs[reg_index][8*b +: 8] <= a_data[8*b +: 8];
                    end
                end
            end
        end else if ((state == FULL) && d_ready) begin
            state   <= EMPTY;
            d_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tlul_reg_responder.sv
// Directed scoreboard bench for tlul_reg_responder.
module tb_tlul_reg_responder;

    localparam logic [31:0] B = 32'h0002_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        a_ready;
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [1:0]  d_source;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;
    logic        d_ready;
    logic [7:0]  err_count;

    tlul_reg_responder #(
        .BASE_ADDR (B),
        .NUM_REGS  (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .a_corrupt (a_corrupt),
        .a_ready   (a_ready),
        .d_valid   (d_valid),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_denied  (d_denied),
        .d_data    (d_data),
        .d_corrupt (d_corrupt),
        .d_ready   (d_ready),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  opcode;
        logic [3:0]  size;
        logic [1:0]  source;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
        logic        chk_data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  src_ctr = 2'd0;
    int          last_wait;
    logic [1:0]  saved_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: a beat presented with d_ready high is consumed at the next edge.
    always @(negedge clock) begin
        if (!reset && d_valid && d_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response opcode=%0h data=%0h expected=none", d_opcode, d_data);
            end else begin
                mon_e = sb.pop_front();
                chk("d_opcode", 32'(d_opcode), 32'(mon_e.opcode));
                chk("d_param", 32'(d_param), 32'd0);
                chk("d_size", 32'(d_size), 32'(mon_e.size));
                chk("d_source", 32'(d_source), 32'(mon_e.source));
                chk("d_denied", 32'(d_denied), 32'(mon_e.denied));
                chk("d_corrupt", 32'(d_corrupt), 32'(mon_e.corrupt));
                if (mon_e.chk_data) chk("d_data", d_data, mon_e.data);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge with a_valid still high.
    task automatic issue(input logic [2:0] op, input logic [3:0] size, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data, input logic corr,
                         input logic [2:0] eop, input logic eden, input logic [31:0] edata,
                         input logic ecorr, input logic echk);
        bit accepted = 0;
        exp_t e;
        a_valid   = 1'b1;
        a_opcode  = op;
        a_param   = 3'($urandom_range(7));
        a_size    = size;
        a_source  = src_ctr;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_corrupt = corr;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (a_ready) begin
                e.opcode = eop; e.size = size; e.source = src_ctr; e.denied = eden;
                e.data = edata; e.corrupt = ecorr; e.chk_data = echk;
                sb.push_back(e);
                accepted = 1;
                last_wait = n;
                break;
            end
        end
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL accept_timeout actual=no_accept expected=accept addr=%0h", addr);
        end
        @(posedge clock);
        #1;
        src_ctr = src_ctr + 2'd1;
    endtask

    task automatic idle();
        a_valid = 1'b0;
    endtask

    task automatic settle_and_check_err(input string name, input logic [7:0] exp);
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk(name, 32'(err_count), 32'(exp));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; d_ready = 1'b1;
        a_valid = 0; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
        a_address = 0; a_mask = 0; a_data = 0; a_corrupt = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_a_ready", 32'(a_ready), 32'd0);
        chk("reset_d_valid", 32'(d_valid), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);
        chk("reset_d_data", d_data, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Full write, read back, partial byte write, read back.
        issue(3'd0, 4'd2, B + 8, 4'hF, 32'hDEADBEEF, 0, 3'd0, 0, 32'h0, 0, 0);
        issue(3'd4, 4'd2, B + 8, 4'h0, 32'h0, 0, 3'd1, 0, 32'hDEADBEEF, 0, 1);
        issue(3'd1, 4'd2, B + 8, 4'b0010, 32'h0000_5500, 0, 3'd0, 0, 32'h0, 0, 0);
        issue(3'd4, 4'd2, B + 8, 4'hF, 32'h0, 0, 3'd1, 0, 32'hDEAD55EF, 0, 1);

        // Out of range and misaligned Gets.
        issue(3'd4, 4'd2, B + 64, 4'hF, 32'h0, 0, 3'd1, 1, 32'h0, 1, 1);
        issue(3'd4, 4'd2, B + 2, 4'hF, 32'h0, 0, 3'd1, 1, 32'h0, 1, 1);
        settle_and_check_err("err_count_two", 8'd2);

        // Other illegal forms: wrong full mask, unsupported opcode, corrupt, below base, size 3.
        issue(3'd0, 4'd0, B + 9, 4'b0001, 32'hFFFFFFFF, 0, 3'd0, 1, 32'h0, 0, 1);
        issue(3'd2, 4'd2, B + 8, 4'hF, 32'hFFFFFFFF, 0, 3'd0, 1, 32'h0, 0, 1);
        issue(3'd1, 4'd2, B + 8, 4'hF, 32'h0, 1, 3'd0, 1, 32'h0, 0, 1);
        issue(3'd4, 4'd2, B - 4, 4'hF, 32'h0, 0, 3'd1, 1, 32'h0, 1, 1);
        issue(3'd4, 4'd3, B, 4'hF, 32'h0, 0, 3'd1, 1, 32'h0, 1, 1);
        settle_and_check_err("err_count_seven", 8'd7);
        issue(3'd4, 4'd2, B + 8, 4'hF, 32'h0, 0, 3'd1, 0, 32'hDEAD55EF, 0, 1);

        // Legal byte-sized full write at an odd lane, and the last register.
        issue(3'd0, 4'd0, B + 9, 4'b0010, 32'h0000_AA00, 0, 3'd0, 0, 32'h0, 0, 0);
        issue(3'd4, 4'd2, B + 8, 4'hF, 32'h0, 0, 3'd1, 0, 32'hDEADAAEF, 0, 1);
        issue(3'd0, 4'd2, B + 60, 4'hF, 32'h12345678, 0, 3'd0, 0, 32'h0, 0, 0);
        issue(3'd4, 4'd2, B + 60, 4'hF, 32'h0, 0, 3'd1, 0, 32'h12345678, 0, 1);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            issue(3'd4, 4'd2, B + 64, 4'hF, 32'h0, 0, 3'd1, 1, 32'h0, 1, 1);
        end
        settle_and_check_err("err_count_saturated", 8'hFF);

        // Backpressure: response held, then drain and accept in the same cycle.
        d_ready = 1'b0;
        saved_src = src_ctr;
        issue(3'd4, 4'd2, B + 8, 4'hF, 32'h0, 0, 3'd1, 0, 32'hDEADAAEF, 0, 1);
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("stall_a_ready", 32'(a_ready), 32'd0);
            chk("stall_d_valid", 32'(d_valid), 32'd1);
            chk("stall_d_data", d_data, 32'hDEADAAEF);
            chk("stall_d_opcode", 32'(d_opcode), 32'd1);
            chk("stall_d_source", 32'(d_source), 32'(saved_src));
        end
        @(posedge clock);
        #1;
        d_ready = 1'b1;
        issue(3'd4, 4'd2, B + 60, 4'hF, 32'h0, 0, 3'd1, 0, 32'h12345678, 0, 1);
        chk("accept_while_draining", 32'(last_wait), 32'd0);
        idle();
        @(negedge clock);
        chk("refill_d_valid", 32'(d_valid), 32'd1);
        chk("refill_d_data", d_data, 32'h12345678);
        @(posedge clock);
        #1;

        // Reset while a response is buffered.
        d_ready = 1'b0;
        issue(3'd4, 4'd2, B + 8, 4'hF, 32'h0, 0, 3'd1, 0, 32'hDEADAAEF, 0, 1);
        idle();
        @(negedge clock);
        chk("pre_reset_d_valid", 32'(d_valid), 32'd1);
        @(posedge clock);
        #1 reset = 1'b1;
        void'(sb.pop_back());
        @(negedge clock);
        chk("reset_midop_a_ready", 32'(a_ready), 32'd0);
        @(posedge clock);
        @(negedge clock);
        chk("reset_midop_d_valid", 32'(d_valid), 32'd0);
        chk("reset_midop_err_count", 32'(err_count), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        d_ready = 1'b1;
        issue(3'd4, 4'd2, B, 4'hF, 32'h0, 0, 3'd1, 0, 32'h0, 0, 1);
        issue(3'd4, 4'd2, B + 8, 4'hF, 32'h0, 0, 3'd1, 0, 32'h0, 0, 1);
        idle();

        for (int n = 0; n < 20; n++) begin
            if (sb.size() == 0) break;
            @(posedge clock);
        end
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlul_reg_responder.md
TLUL_REG_RESPONDER -- requirements
Module: tlul_reg_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0002_0000, base byte address of the register window.
REQ-002 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers; the window spans NUM_REGS*4 bytes; legal values are powers of two from 1 to 64.
REQ-003 SHALL have port clock, input, 1, the single clock for all state.
REQ-004 SHALL have port reset, input, 1, with synchronous, active-high reset.
REQ-005 SHALL have A-channel inputs a_valid (1), a_opcode (3), a_param (3), a_size (4), a_source (2), a_address (32), a_mask (4), a_data (32), a_corrupt (1), plus output a_ready (1).
REQ-006 SHALL have D-channel outputs d_valid (1), d_opcode (3), d_param (2), d_size (4), d_source (2), d_denied (1), d_data (32), d_corrupt (1), plus input d_ready (1).
REQ-007 SHALL have output err_count, 8 bits, a saturating count of denied requests.

Function
REQ-008 SHALL act as a TL-UL responder with a one-entry response buffer; FSM states are EMPTY and FULL.
REQ-009 SHALL drive a_ready = (state==EMPTY) | d_ready, allowing accept and drain in the same cycle.
REQ-010 SHALL accept an A beat when a_valid & a_ready, and enter FULL on the next cycle with d_valid=1 (latency 1 cycle).
REQ-011 SHALL transition FULL->EMPTY on d_ready without a new accept, and stay FULL on simultaneous drain and accept, replacing the buffered response.
REQ-012 SHALL hold all D outputs stable while d_valid & !d_ready.
REQ-013 SHALL treat a request as legal only if all of the following hold: opcode is Get(4), PutFullData(0) or PutPartialData(1); a_size <= 2; a_address is aligned to 2^a_size; a_address lies in [BASE_ADDR, BASE_ADDR+NUM_REGS*4); a_corrupt=0.
REQ-014 SHALL additionally require, for PutFullData, that a_mask equals the contiguous lane mask implied by a_size and a_address[1:0]; otherwise the request is illegal.
REQ-015 SHALL, for a legal Put, update only the bytes of the register at index a_address[2+:log2(NUM_REGS)] whose a_mask bits are set, in the accept cycle.
REQ-016 SHALL, for a legal Get, capture the full 32-bit register value at accept into d_data; a_mask is ignored.
REQ-017 SHALL produce response fields as follows: d_opcode = AccessAckData(1) for Get and AccessAck(0) for Put; d_param=0; d_size and d_source echo the request.
REQ-018 SHALL, for an illegal request, cause no register change and respond with d_denied=1; d_corrupt=1 if the opcode is Get, else 0; d_data=0.
REQ-019 SHALL treat an unsupported opcode as illegal and answer it with AccessAck and d_denied=1.
REQ-020 SHALL increment err_count by 1 per accepted illegal request and saturate it at 8'hFF.
REQ-021 SHALL ignore a_param.

Reset
REQ-022 SHALL, while reset=1 at a clock edge, set state to EMPTY, d_valid to 0, all registers to 0, err_count to 0, and all other D fields to 0.
REQ-023 SHALL drop a response buffered when reset is asserted mid-operation, without presenting it; a_ready SHALL be 0 during reset.

Structure
REQ-024 SHALL take TL opcode constants (Get, PutFullData, PutPartialData, AccessAck, AccessAckData) and the 2-state FSM enum from a shared package, tlul_pkg.
REQ-025 SHALL place the legality check (REQ-013/014) in one combinational sub-module, tlul_req_check, which outputs legal and reg_index.

Verification
REQ-026 SHALL cover: PutFullData size 2, address BASE+8, data 32'hDEADBEEF, mask 4'hF, then Get BASE+8 -> AccessAck, then AccessAckData with d_data=32'hDEADBEEF, d_denied=0.
REQ-027 SHALL cover: PutPartialData at BASE+8 with mask 4'b0010 and data 32'h0000_5500 over DEADBEEF, then Get -> d_data=32'hDEAD55EF.
REQ-028 SHALL cover: Get at BASE+NUM_REGS*4 (out of range) and Get size 2 at BASE+2 (misaligned) -> both d_denied=1, d_corrupt=1, err_count=2.
REQ-029 SHALL cover: d_ready held 0 for 5 cycles after a Get -> a_ready=0 and D fields stable; then d_ready=1 together with a new a_valid -> accepted that cycle, next response valid the following cycle.
REQ-030 SHALL cover: 300 back-to-back illegal requests -> err_count saturates at 8'hFF.
REQ-031 SHALL cover: reset asserted while d_valid=1 -> next cycle d_valid=0, err_count=0, and a Get at BASE returns 0.
